// File: rtl/freoff_pkg.sv
// freoff_pkg: shared phase-format constants, FSM states and CORDIC arctan table
package freoff_pkg;
    localparam int PI_Q = 25736;
    localparam int TWO_PI_Q = 51472;
    localparam int CORDIC_GAIN_INV = 19898;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
    // atan(2^-i) in 3.13 radians; supports up to 16 stages
    localparam int ATAN [16] = '{6434, 3798, 2007, 1019, 511, 256, 128, 64, 32, 16, 8, 4, 2, 1, 1, 0};
endpackage

// File: rtl/cordic_rot_pipe.sv
// cordic_rot_pipe: rotates a Q1.15 complex sample by a 3.13 phase, output 2.14 {Im, Re}
//   clk/rst/ce  clock, sync reset (valid chain only), clock enable for every stage
//   stb/sample/phase  input valid, {Im, Re} sample, rotation phase in [-PI_Q, PI_Q]
//   vld/rot  final-stage valid and rounded, saturated rotated sample
module cordic_rot_pipe #(
    parameter int ITER = 14,
    parameter int PI_Q = 25736
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ce,
    input  logic               stb,
    input  logic [31:0]        sample,
    input  logic signed [16:0] phase,
    output logic               vld,
    output logic [31:0]        rot
);
    import freoff_pkg::*;
    localparam logic signed [16:0] PQ = 17'(PI_Q);
    localparam logic signed [16:0] HQ = 17'(PI_Q / 2);
    localparam logic signed [15:0] G = 16'(CORDIC_GAIN_INV);
    // 18-bit datapath holds the raw Q1.15 value, i.e. 2.14 with one guard bit
    logic signed [17:0] x [0:ITER];
    logic signed [17:0] y [0:ITER];
    logic signed [16:0] z [0:ITER-1];
    logic signed [33:0] px, py;
    logic signed [17:0] x0, y0;
    logic [ITER+1:0] v;
    logic flip;
    assign x0 = 18'($signed(sample[15:0]));
    assign y0 = 18'($signed(sample[31:16]));
    assign flip = phase > HQ || phase < -HQ;
    always_ff @(posedge clk)
        if (rst) v <= '0;
        else if (ce) v <= {v[ITER:0], stb};
    always_ff @(posedge clk)
        if (ce) begin
            x[0] <= flip ? -x0 : x0;
            y[0] <= flip ? -y0 : y0;
            z[0] <= phase > HQ ? phase - PQ : phase < -HQ ? phase + PQ : phase;
            for (int i = 0; i < ITER; i++) begin
                x[i+1] <= z[i][16] ? x[i] + (y[i] >>> i) : x[i] - (y[i] >>> i);
                y[i+1] <= z[i][16] ? y[i] - (x[i] >>> i) : y[i] + (x[i] >>> i);
            end
            for (int i = 0; i < ITER - 1; i++)
                z[i+1] <= z[i][16] ? z[i] + 17'(ATAN[i]) : z[i] - 17'(ATAN[i]);
            px <= 34'(x[ITER]) * 34'(G);
            py <= 34'(y[ITER]) * 34'(G);
        end
    // drop the guard bit and the Q15 gain scale with round-half-up, then clamp
    function automatic logic [15:0] sat(input logic signed [33:0] a);
        logic signed [17:0] r;
        r = 18'((a + 34'sd32768) >>> 16);
        return r > 18'sd32767 ? 16'h7fff : r < -18'sd32768 ? 16'h8000 : r[15:0];
    endfunction
    assign vld = v[ITER+1];
    assign rot = {sat(py), sat(px)};
endmodule

// File: rtl/freoff_inject.sv
// freoff_inject: TX carrier-frequency-offset injector, rotates sample n of a frame by n*step
//   ena/ce  frame enable (rising edge starts a frame), clock enable for accumulator and pipeline
//   dat_in/stb_in  {Im, Re} Q1.15 sample and its valid
//   phase_step/ld_step  3.13 per-sample increment and its load strobe
//   dat_out/out_val  rotated 2.14 {Im, Re} sample and its one-clock valid pulse
module freoff_inject #(
    parameter int ITER = 14,
    parameter int PI_Q = 25736
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ena,
    input  logic        ce,
    input  logic [31:0] dat_in,
    input  logic        stb_in,
    input  logic [15:0] phase_step,
    input  logic        ld_step,
    output logic [31:0] dat_out,
    output logic        out_val
);
    import freoff_pkg::*;
    localparam int DW = $clog2(ITER + 3);
    localparam logic signed [16:0] PQ = 17'(PI_Q);
    localparam logic signed [16:0] TPQ = 17'(2 * PI_Q);
    state_t st;
    logic ena_d, pend, val_q, pv, acc_ok;
    logic signed [15:0] step;
    logic signed [16:0] acc, sum, nxt;
    logic [DW-1:0] dcnt;
    logic [31:0] pd;
    assign acc_ok = st == RUN && ena && stb_in && ce;
    assign sum = acc + 17'(step);
    assign nxt = sum > PQ ? sum - TPQ : sum < -PQ ? sum + TPQ : sum;
    cordic_rot_pipe #(.ITER(ITER), .PI_Q(PI_Q)) u_pipe (
        .clk    (clk),
        .rst    (rst),
        .ce     (ce),
        .stb    (acc_ok),
        .sample (dat_in),
        .phase  (acc),
        .vld    (pv),
        .rot    (pd)
    );
    // pend remembers an ena rising edge seen during DRAIN so IDLE can act on it
    always_ff @(posedge clk)
        if (rst) begin
            st <= IDLE;
            ena_d <= 1'b0;
            pend <= 1'b0;
            step <= '0;
            acc <= '0;
            dcnt <= '0;
        end else begin
            ena_d <= ena;
            case (st)
                IDLE: begin
                    pend <= 1'b0;
                    if (ena && (!ena_d || pend)) begin
                        st <= RUN;
                        acc <= '0;
                        step <= phase_step;
                    end
                end
                RUN:
                    if (!ena) begin
                        st <= DRAIN;
                        dcnt <= '0;
                    end else begin
                        if (acc_ok) acc <= nxt;
                        if (ld_step) step <= phase_step;
                    end
                default: begin
                    pend <= ena && (pend || !ena_d);
                    if (ce) begin
                        dcnt <= dcnt + 1'b1;
                        if (dcnt == DW'(ITER + 2)) st <= IDLE;
                    end
                end
            endcase
        end
    always_ff @(posedge clk)
        if (rst) begin
            dat_out <= '0;
            val_q <= 1'b0;
        end else if (ce) begin
            val_q <= pv;
            if (pv) dat_out <= pd;
        end
    // a loaded result waits through ce-low cycles and is presented in the next ce-high cycle
    assign out_val = val_q & ce;
endmodule

// File: tb/tb_freoff_inject.sv
// tb_freoff_inject: randomized scoreboard bench for freoff_inject against a trig reference model
`timescale 1ns/1ps
module tb_freoff_inject;
    import freoff_pkg::*;
    localparam int ITER = 14, PQ = 25736, T2 = 2 * PQ, LAT = ITER + 3, TOL = 6;
    logic clk = 0, rst = 1, ena = 0, ce = 1, stb_in = 0, ld_step = 0;
    logic [31:0] dat_in = 0;
    logic [15:0] phase_step = 0;
    logic [31:0] dat_out;
    logic out_val;
    typedef struct { int re; int im; int t; } exp_t;
    exp_t q[$];
    exp_t e;
    int checks = 0, failures = 0, ce_edges = 0, step_m = 0, s;
    bit in_run = 0;
    longint tot = 0;

    freoff_inject #(.ITER(ITER), .PI_Q(PQ)) dut (
        .clk        (clk),
        .rst        (rst),
        .ena        (ena),
        .ce         (ce),
        .dat_in     (dat_in),
        .stb_in     (stb_in),
        .phase_step (phase_step),
        .ld_step    (ld_step),
        .dat_out    (dat_out),
        .out_val    (out_val)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input logic [31:0] d, input longint ph, input int t);
        real a, re, im;
        longint r;
        exp_t x;
        r = ((ph % T2) + T2) % T2;
        if (r > PQ) r -= T2;
        a = real'(r) / 8192.0;
        re = real'($signed(d[15:0]));
        im = real'($signed(d[31:16]));
        x.re = int'(0.5 * (re * $cos(a) - im * $sin(a)));
        x.im = int'(0.5 * (re * $sin(a) + im * $cos(a)));
        x.t = t;
        return x;
    endfunction

    function automatic logic [31:0] rnd_dat();
        int re = int'($urandom_range(0, 'hA000)) - 'h5000;
        int im = int'($urandom_range(0, 'hA000)) - 'h5000;
        return {16'(im), 16'(re)};
    endfunction

    task automatic chk(input string name, input int act, input int want, input int tol);
        checks++;
        if (act > want + tol || act < want - tol) begin
            failures++;
            $display("FAIL %s: got %0d want %0d (tol %0d) at %0t", name, act, want, tol, $time);
        end
    endtask

    task automatic chk_state(input string name, input state_t want);
        chk(name, int'(dut.st), int'(want), 0);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame(input int st);
        phase_step = 16'(st);
        ena = 1;
        stb_in = 0;
        ce = 1;
        tick;
        in_run = 1;
        tot = 0;
        step_m = st;
    endtask

    task automatic send(input logic [31:0] d, input bit c);
        dat_in = d;
        stb_in = 1;
        ce = c;
        tick;
        stb_in = 0;
        ce = 1;
    endtask

    task automatic stop_frame;
        ena = 0;
        stb_in = 1;
        tick;
        in_run = 0;
        stb_in = 0;
    endtask

    // reference: accepted samples get the running phase sum; ld_step affects later updates only
    always @(posedge clk)
        if (!rst) begin
            if (ce) ce_edges++;
            if (in_run && ena && stb_in && ce) begin
                q.push_back(model(dat_in, tot, ce_edges));
                tot += step_m;
            end
            if (in_run && ena && ld_step) step_m = int'($signed(phase_step));
        end

    always @(negedge clk)
        if (!rst) begin
            if (!ce) chk("quiet_when_ce_low", int'(out_val), 0, 0);
            if (out_val) begin
                if (q.size() == 0) chk("spurious_out_val", int'(out_val), 0, 0);
                else begin
                    e = q.pop_front();
                    chk("re", int'($signed(dat_out[15:0])), e.re, TOL);
                    chk("im", int'($signed(dat_out[31:16])), e.im, TOL);
                    chk("latency", ce_edges - e.t + 1, LAT, 0);
                end
            end
        end

    initial begin
        tick;
        tick;
        chk("rst_dat_out", int'(dat_out), 0, 0);
        chk("rst_out_val", int'(out_val), 0, 0);
        chk_state("rst_state", IDLE);
        rst = 0;
        tick;
        start_frame(0);
        repeat (8) send(32'h0000_4000, 1);
        stop_frame;
        repeat (LAT + 3) tick;
        start_frame(12868);
        repeat (8) send(32'h0000_4000, 1);
        stop_frame;
        repeat (LAT + 3) tick;
        start_frame(25000);
        chk("acc_first", int'(dut.acc), 0, 0);
        send(rnd_dat(), 1);
        chk("acc_second", int'(dut.acc), 25000, 0);
        send(rnd_dat(), 1);
        chk("acc_wrapped", int'(dut.acc), -1472, 0);
        send(rnd_dat(), 1);
        stop_frame;
        repeat (LAT + 3) tick;
        start_frame(3000);
        for (int i = 0; i < 12; i++) send(rnd_dat(), i % 2 == 0);
        stop_frame;
        repeat (LAT + 3) tick;
        start_frame(1000);
        repeat (2) send(rnd_dat(), 1);
        ld_step = 1;
        phase_step = 16'(-7000);
        send(rnd_dat(), 1);
        ld_step = 0;
        repeat (3) send(rnd_dat(), 1);
        ld_step = 1;
        phase_step = 16'(20000);
        tick;
        ld_step = 0;
        repeat (3) send(rnd_dat(), 1);
        stop_frame;
        repeat (LAT + 3) tick;
        start_frame(5000);
        repeat (5) send(rnd_dat(), 1);
        ena = 0;
        stb_in = 1;
        tick;
        in_run = 0;
        for (int i = 1; i <= LAT - 1; i++) begin
            if (i == 5) begin
                ena = 1;
                phase_step = 16'(-9000);
            end
            dat_in = rnd_dat();
            tick;
        end
        chk_state("drain_hold", DRAIN);
        tick;
        chk_state("drain_done", IDLE);
        tick;
        chk_state("deferred_start", RUN);
        in_run = 1;
        tot = 0;
        step_m = -9000;
        stb_in = 0;
        repeat (4) send(rnd_dat(), 1);
        stop_frame;
        repeat (LAT + 3) tick;
        for (int f = 0; f < 4; f++) begin
            start_frame(int'($urandom_range(0, T2)) - PQ);
            for (int i = 0; i < 40; i++) begin
                dat_in = rnd_dat();
                stb_in = $urandom_range(0, 9) < 7;
                ce = $urandom_range(0, 9) < 8;
                ld_step = $urandom_range(0, 9) == 0;
                s = int'($urandom_range(0, T2)) - PQ;
                phase_step = 16'(s);
                tick;
            end
            ld_step = 0;
            ce = 1;
            stop_frame;
            repeat (LAT + 5) tick;
        end
        start_frame(4000);
        repeat (10) send(rnd_dat(), 1);
        rst = 1;
        ena = 0;
        tick;
        q.delete();
        in_run = 0;
        chk("midrst_dat_out", int'(dat_out), 0, 0);
        chk("midrst_out_val", int'(out_val), 0, 0);
        chk_state("midrst_state", IDLE);
        rst = 0;
        repeat (LAT + 5) tick;
        for (int i = 0; i < 200 && q.size() != 0; i++) tick;
        chk("scoreboard_drained", q.size(), 0, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/freoff_inject.md
# freoff_inject

Transmit-side carrier-frequency-offset injector for the 802.16 OFDM chain. It rotates each accepted complex sample by a phase that grows linearly with sample index, producing the offset that the receiver's estimator/compensator must measure and remove. It sits between the TX sample stream and the channel/DAC model. Closed-loop benches use it to drive a known offset into the receiver.

## Interface
Parameters:
- ITER, 14: number of CORDIC rotation stages.
- PI_Q, 25736: π in phase format 3.13 (radians).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-high; one clock, all logic.
- ena  in  1  frame enable; a rising edge starts a frame.
- ce  in  1  clock enable for the phase accumulator and the rotation pipeline.
- dat_in  in  32  sample, {Im[15:0], Re[15:0]}, Q1.15 two's complement.
- stb_in  in  1  dat_in valid.
- phase_step  in  16  per-sample phase increment, format 3.13, legal range [-PI_Q, PI_Q].
- ld_step  in  1  load phase_step into the step register.
- dat_out  out  32  rotated sample, {Im, Re}, format 2.14 per component.
- out_val  out  1  one-clock pulse per valid dat_out.

## Operation
- FSM states:
  - IDLE: ena=0, no samples accepted.
  - RUN: samples accepted.
  - DRAIN: flushing the pipeline.
- IDLE→RUN when ena=1 and ena_d=0. On that transition the accumulator is cleared to 0 and phase_step is captured into the step register.
- In RUN, a sample is accepted when stb_in & ce.
  - The sample enters the pipeline tagged with the current accumulator value.
  - The accumulator then updates to acc+step, wrapped as follows: result > PI_Q subtracts 2·PI_Q; result < -PI_Q adds 2·PI_Q.
  - Sample n of a frame (n from 0) is therefore rotated by n·step mod 2π.
- ld_step in RUN loads phase_step into the step register without clearing the accumulator. The new step applies to the accumulator update made by the next accepted sample. If ld_step coincides with an accepted sample, that sample's update still uses the old step.
- RUN→DRAIN when ena=0. A stb_in on that same cycle is not accepted.
- In DRAIN, stb_in is ignored. DRAIN lasts ITER+3 ce-qualified cycles, counted by a drain counter, then →IDLE.
- A rising edge of ena while in DRAIN is deferred and acted on in IDLE; no frame restarts mid-drain.
- Rotation pipeline:
  - Input conversion: x = {Re[15],Re[15:1]}, y = {Im[15],Im[15:1]} (2.14).
  - Quadrant pre-rotation: if |phase| > PI_Q/2, the sample is negated and the residual phase reduced by ±PI_Q.
  - ITER CORDIC rotation stages, internal width 18 bits.
  - Gain correction ×19898 (0.60725, Q1.15), then rounding and saturation to 16 bits each.
- Signed arithmetic throughout. The accumulator is 17 bits internally so wrap detection cannot overflow.

## Timing
- Latency: ITER+3 ce-high cycles from an accepted sample to out_val (17 with defaults).
- ce=0 freezes all pipeline and accumulator registers, and out_val is 0 on that cycle.
- Throughput: one sample per ce-high cycle; back-to-back stb_in is allowed.
- The output register loads dat_out and pulses out_val for one clock only when the final valid bit is set and ce=1. dat_out holds its last value otherwise.
- Reset values: dat_out=0, out_val=0, FSM=IDLE, accumulator=0, step=0, all pipeline valid bits=0, ena_d=0.
- Reset mid-frame clears all in-flight samples; no out_val follows.

## Structure
- Shared package freoff_pkg:
  - Phase format constants: PI_Q, TWO_PI_Q=51472, CORDIC_GAIN_INV=19898.
  - FSM state enum {IDLE, RUN, DRAIN}.
  - CORDIC arctan table (ITER entries, 3.13).
- One sub-module, cordic_rot_pipe: pre-rotation, ITER stages, gain correction, saturation, and a valid chain, all ce-gated.
- Top level: FSM, ena edge detect, step register, phase accumulator with wrap, drain counter, output register.

## Test plan
- step=0, Re=0x4000, Im=0, 8 samples → 8 out_val pulses, each 17 cycles after its input; Re=0x2000±2, Im=0±2.
- step=12868 (π/2), Re=0x4000 constant → outputs rotate (0x2000,0), (0,0x2000), (0xE000,0), (0,0xE000) ±2 LSB.
- Wrap: step=25000, three samples → accumulator 0, 25000, then -1472 (50000-51472); third output matches a -1472 rotation.
- ce toggled 1,0,1,0 with continuous stb_in → one sample accepted per ce-high cycle; out_val never high while ce=0; latency counts ce-high cycles only.
- ena drops with 5 samples in flight → all 5 emerge, stb_in in DRAIN is ignored, FSM returns to IDLE after 17 ce cycles; a new ena edge restarts with phase 0.
- rst asserted for one clock mid-RUN with 10 samples in flight → no out_val afterwards; dat_out=0 and FSM=IDLE on the next clock.
